// File: rtl/rsa_pkg.sv
// Shared types and constants for the radix-2 Montgomery multiplier.
package rsa_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      CORR = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/rsa_mont_step.sv
// One radix-2 Montgomery iteration: R' = (R + a_i*b + q*m) >> 1, q chosen to make the sum even.
module rsa_mont_step
   import rsa_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH+1:0] r,
   input  logic             a_i,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH+1:0] r_next_c
);

   localparam int unsigned RW = WIDTH + 2;

   logic [RW-1:0] sum_ab;
   logic [RW-1:0] sum_q;

   // R stays below 2m, so R + b + m < 4m fits in WIDTH+2 bits.
   always_comb begin
      sum_ab   = r + (a_i ? RW'(b) : RW'(0));
      sum_q    = sum_ab + (sum_ab[0] ? RW'(m) : RW'(0));
      r_next_c = sum_q >> 1;
   end

endmodule

// File: rtl/rsa_mont_mult.sv
// Bit-serial Montgomery multiplier: result = a*b*2^-WIDTH mod m, one multiplier bit per cycle.
module rsa_mont_mult
   import rsa_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] m,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int unsigned RW    = WIDTH + 2;
   localparam int unsigned CNT_W = $clog2(WIDTH);

   state_t             state;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   m_q;
   logic [RW-1:0]      r_q;
   logic [RW-1:0]      r_next_c;
   logic [WIDTH-1:0]   corr_c;
   logic [CNT_W-1:0]   cnt;

   // a_q is shifted right each CALC cycle so bit 0 is always the current multiplier bit.
   rsa_mont_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .r        (r_q),
      .a_i      (a_q[0]),
      .b        (b_q),
      .m        (m_q),
      .r_next_c (r_next_c)
   );

   // Final conditional subtraction; R < 2m so one subtraction is enough.
   always_comb begin
      corr_c = (r_q >= RW'(m_q)) ? WIDTH'(r_q - RW'(m_q)) : WIDTH'(r_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         m_q    <= '0;
         r_q    <= '0;
         cnt    <= '0;
         result <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (m[0]) begin
                     a_q   <= a;
                     b_q   <= b;
                     m_q   <= m;
                     r_q   <= '0;
                     cnt   <= '0;
                     busy  <= 1'b1;
                     err   <= 1'b0;
                     state <= CALC;
                  end else begin
                     // Even modulus has no inverse of 2; report and finish at once.
                     err    <= 1'b1;
                     result <= '0;
                     done   <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            CALC: begin
               r_q <= r_next_c;
               a_q <= a_q >> 1;
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state <= CORR;
               end
            end
            CORR: begin
               result <= corr_c;
               busy   <= 1'b0;
               done   <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
